led_status_driver: RTL and testbench



---
 rtl/led_status_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_led_status_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_status_driver.sv
// Front-panel LED pattern source: turns system, PSU, fan and LAN status into
// registered, active-low, blink-encoded LED drive, with a power-on lamp test
// and per-port stretching of LAN activity pulses.
module led_status_driver #(
  parameter int unsigned SLOW_HALF = 16384,
  parameter int unsigned FAST_HALF = 4096,
  parameter int unsigned ACT_HOLD  = 1638,
  parameter int unsigned LT_CYC    = 16384
) (
  input  logic       CLK32768,
  input  logic       Reset,
  input  logic       FM_PS_EN,
  input  logic [1:0] SysGreenMode,
  input  logic [1:0] SysRedMode,
  input  logic [1:0] PsuOk,
  input  logic [1:0] PsuFail,
  input  logic       FanFail,
  input  logic [1:0] LanLink1000,
  input  logic [1:0] LanLink100,
  input  logic [1:0] LanAct,
  output logic       SysLedG_ox,
  output logic       SysLedR_ox,
  output logic [1:0] PowerNormal_ox,
  output logic [1:0] PowerFail_ox,
  output logic       FanFail_ox,
  output logic       FanOK_ox,
  output logic [1:0] RJ45Speed1R_ox,
  output logic [1:0] RJ45Speed2R_ox,
  output logic [1:0] RJ45RActivity_ox
);

  localparam int unsigned SLOW_W = $clog2(SLOW_HALF);
  localparam int unsigned FAST_W = $clog2(FAST_HALF);
  localparam int unsigned ACT_W  = $clog2(ACT_HOLD);
  localparam int unsigned LT_W   = $clog2(LT_CYC);
  localparam int unsigned LED_W  = 14;

  localparam logic [1:0] LT_NORMAL = 2'd0;
  localparam logic [1:0] LT_ON     = 2'd1;
  localparam logic [1:0] LT_OFF    = 2'd2;

  localparam logic [1:0] ACT_IDLE  = 2'd0;
  localparam logic [1:0] ACT_ON    = 2'd1;
  localparam logic [1:0] ACT_OFF   = 2'd2;

  logic [SLOW_W-1:0] slow_cnt;
  logic [FAST_W-1:0] fast_cnt;
  logic              slow_ph;
  logic              fast_ph;
  logic              ps_en_q;
  logic [1:0]        lt_state;
  logic [1:0]        lt_state_n;
  logic [LT_W-1:0]   lt_cnt;
  logic [LT_W-1:0]   lt_cnt_n;
  logic [1:0]        act_lit;
  logic              red_lit;
  logic              green_lit;
  logic [LED_W-1:0]  lit_c;
  logic [LED_W-1:0]  led_q;

  // Lit decision for a 2-bit blink mode: off, solid, slow phase, fast phase.
  function automatic logic mode_lit(input logic [1:0] mode, input logic slow, input logic fast);
    case (mode)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return slow;
      default: return fast;
    endcase
  endfunction

  // Shared slow/fast blink prescalers; phase 1 is the lit half.
  always_ff @(posedge CLK32768) begin
    if (Reset) begin
      slow_cnt <= '0;
      slow_ph  <= 1'b0;
      fast_cnt <= '0;
      fast_ph  <= 1'b0;
    end else begin
      if (slow_cnt == SLOW_W'(SLOW_HALF - 1)) begin
        slow_cnt <= '0;
        slow_ph  <= ~slow_ph;
      end else begin
        slow_cnt <= slow_cnt + SLOW_W'(1);
      end
      if (fast_cnt == FAST_W'(FAST_HALF - 1)) begin
        fast_cnt <= '0;
        fast_ph  <= ~fast_ph;
      end else begin
        fast_cnt <= fast_cnt + FAST_W'(1);
      end
    end
  end

  // Lamp-test state register and registered PSU enable for edge detection.
  always_ff @(posedge CLK32768) begin
    if (Reset) begin
      lt_state <= LT_NORMAL;
      lt_cnt   <= '0;
      ps_en_q  <= 1'b0;
    end else begin
      lt_state <= lt_state_n;
      lt_cnt   <= lt_cnt_n;
      ps_en_q  <= FM_PS_EN;
    end
  end

  // Lamp-test next state: rising PSU enable starts it, losing enable aborts it.
  always_comb begin
    lt_state_n = lt_state;
    lt_cnt_n   = lt_cnt + LT_W'(1);
    case (lt_state)
      LT_NORMAL: begin
        lt_cnt_n = '0;
        if (FM_PS_EN && !ps_en_q) lt_state_n = LT_ON;
      end
      LT_ON: begin
        if (!FM_PS_EN) begin
          lt_state_n = LT_NORMAL;
          lt_cnt_n   = '0;
        end else if (lt_cnt == LT_W'(LT_CYC - 1)) begin
          lt_state_n = LT_OFF;
          lt_cnt_n   = '0;
        end
      end
      LT_OFF: begin
        if (!FM_PS_EN || (lt_cnt == LT_W'(LT_CYC - 1))) begin
          lt_state_n = LT_NORMAL;
          lt_cnt_n   = '0;
        end
      end
      default: begin
        lt_state_n = LT_NORMAL;
        lt_cnt_n   = '0;
      end
    endcase
  end

  // Per-port activity stretcher: lit for ACT_HOLD, dark for ACT_HOLD, then rearm.
  for (genvar p = 0; p < 2; p++) begin : g_act
    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [ACT_W-1:0] cnt;
    logic [ACT_W-1:0] cnt_n;
    logic             link;

    assign link       = LanLink1000[p] | LanLink100[p];
    assign act_lit[p] = (state == ACT_ON);

    // Activity state register.
    always_ff @(posedge CLK32768) begin
      if (Reset) begin
        state <= ACT_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end

    // Activity next state; link loss returns to idle from anywhere.
    always_comb begin
      state_n = state;
      cnt_n   = cnt + ACT_W'(1);
      case (state)
        ACT_IDLE: begin
          cnt_n = '0;
          if (LanAct[p]) state_n = ACT_ON;
        end
        ACT_ON: begin
          if (cnt == ACT_W'(ACT_HOLD - 1)) begin
            state_n = ACT_OFF;
            cnt_n   = '0;
          end
        end
        ACT_OFF: begin
          if (cnt == ACT_W'(ACT_HOLD - 1)) begin
            state_n = ACT_IDLE;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ACT_IDLE;
          cnt_n   = '0;
        end
      endcase
      if (!link) begin
        state_n = ACT_IDLE;
        cnt_n   = '0;
      end
    end
  end

  // Normal-mode lit pattern; red overrides green, PSU fail overrides PSU ok.
  always_comb begin
    red_lit   = mode_lit(SysRedMode, slow_ph, fast_ph);
    green_lit = (SysRedMode != 2'b00) ? 1'b0 : mode_lit(SysGreenMode, slow_ph, fast_ph);
    lit_c     = {green_lit, red_lit,
                 PsuOk & ~PsuFail, PsuFail,
                 FanFail, ~FanFail,
                 LanLink1000, ~LanLink1000 & LanLink100,
                 act_lit};
  end

  // Registered active-low LED drive with lamp-test override.
  always_ff @(posedge CLK32768) begin
    if (Reset) begin
      led_q <= '1;
    end else begin
      case (lt_state)
        LT_ON:   led_q <= '0;
        LT_OFF:  led_q <= '1;
        default: led_q <= ~lit_c;
      endcase
    end
  end

  assign {SysLedG_ox, SysLedR_ox, PowerNormal_ox, PowerFail_ox, FanFail_ox, FanOK_ox,
          RJ45Speed1R_ox, RJ45Speed2R_ox, RJ45RActivity_ox} = led_q;

endmodule

// File: tb/tb_led_status_driver.sv
// Scoreboard bench for led_status_driver: a timer-based reference model pushes
// the expected LED word per cycle; a negedge monitor pops and compares.
module tb_led_status_driver;

  localparam int unsigned SLOW = 8;
  localparam int unsigned FAST = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned LT   = 10;

  logic       clk = 1'b0;
  logic       Reset, FM_PS_EN, FanFail;
  logic [1:0] SysGreenMode, SysRedMode, PsuOk, PsuFail, LanLink1000, LanLink100, LanAct;
  logic       SysLedG_ox, SysLedR_ox, FanFail_ox, FanOK_ox;
  logic [1:0] PowerNormal_ox, PowerFail_ox, RJ45Speed1R_ox, RJ45Speed2R_ox, RJ45RActivity_ox;

  logic [13:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          done   = 1'b0;

  // Reference model state: cycles since reset, remaining lamp-test and activity time.
  int   n_edges;
  int   lt_left;
  int   act_left[2];
  logic ps_prev;

  always #5 clk = ~clk;

  led_status_driver #(
    .SLOW_HALF(SLOW), .FAST_HALF(FAST), .ACT_HOLD(HOLD), .LT_CYC(LT)
  ) dut (
    .CLK32768(clk), .Reset(Reset), .FM_PS_EN(FM_PS_EN),
    .SysGreenMode(SysGreenMode), .SysRedMode(SysRedMode),
    .PsuOk(PsuOk), .PsuFail(PsuFail), .FanFail(FanFail),
    .LanLink1000(LanLink1000), .LanLink100(LanLink100), .LanAct(LanAct),
    .SysLedG_ox(SysLedG_ox), .SysLedR_ox(SysLedR_ox),
    .PowerNormal_ox(PowerNormal_ox), .PowerFail_ox(PowerFail_ox),
    .FanFail_ox(FanFail_ox), .FanOK_ox(FanOK_ox),
    .RJ45Speed1R_ox(RJ45Speed1R_ox), .RJ45Speed2R_ox(RJ45Speed2R_ox),
    .RJ45RActivity_ox(RJ45RActivity_ox)
  );

  function automatic logic lit_of(input logic [1:0] m, input logic s, input logic f);
    if (m == 2'd0) return 1'b0;
    if (m == 2'd1) return 1'b1;
    if (m == 2'd2) return s;
    return f;
  endfunction

  // Push the word the DUT should show after the next edge, then advance the model.
  task automatic tick();
    logic [13:0] e;
    logic        sph, fph, r, g;
    logic [1:0]  al;
    if (Reset) begin
      e = '1;
      n_edges = 0; lt_left = 0; ps_prev = 1'b0;
      act_left[0] = 0; act_left[1] = 0;
    end else begin
      sph = ((n_edges / SLOW) % 2) == 1;
      fph = ((n_edges / FAST) % 2) == 1;
      r   = lit_of(SysRedMode, sph, fph);
      g   = (SysRedMode != 2'd0) ? 1'b0 : lit_of(SysGreenMode, sph, fph);
      for (int i = 0; i < 2; i++) al[i] = act_left[i] > HOLD;
      if (lt_left > LT)     e = '0;
      else if (lt_left > 0) e = '1;
      else e = ~{g, r, PsuOk & ~PsuFail, PsuFail, FanFail, ~FanFail,
                 LanLink1000, ~LanLink1000 & LanLink100, al};
      n_edges++;
      if (lt_left > 0) lt_left = FM_PS_EN ? lt_left - 1 : 0;
      else if (FM_PS_EN && !ps_prev) lt_left = 2 * LT;
      ps_prev = FM_PS_EN;
      for (int i = 0; i < 2; i++) begin
        if (!(LanLink1000[i] | LanLink100[i])) act_left[i] = 0;
        else if (act_left[i] > 0)              act_left[i] = act_left[i] - 1;
        else if (LanAct[i])                    act_left[i] = 2 * HOLD;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: every cycle the DUT presents a fresh LED word.
  initial begin : monitor
    logic [13:0] e, got;
    forever begin
      @(negedge clk);
      if (!done) begin
        got = {SysLedG_ox, SysLedR_ox, PowerNormal_ox, PowerFail_ox, FanFail_ox, FanOK_ox,
               RJ45Speed1R_ox, RJ45Speed2R_ox, RJ45RActivity_ox};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty t=%0t got=%b", $time, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL leds t=%0t got=%b exp=%b", $time, got, e);
          end
        end
      end
    end
  end

  initial begin : stimulus
    Reset = 1'b1; FM_PS_EN = 1'b1; FanFail = 1'b0;
    SysGreenMode = 2'b01; SysRedMode = 2'b00; PsuOk = 2'b00; PsuFail = 2'b00;
    LanLink1000 = 2'b00; LanLink100 = 2'b00; LanAct = 2'b00;
    run(3);
    Reset = 1'b0;
    run(30);
    // Blink modes and red-over-green priority.
    SysGreenMode = 2'b10; run(24);
    SysRedMode = 2'b11;   run(10);
    SysRedMode = 2'b10;   run(20);
    SysRedMode = 2'b00; SysGreenMode = 2'b11; run(8);
    // PSU, fan and link decode.
    PsuOk = 2'b11; PsuFail = 2'b01; FanFail = 1'b1; run(3);
    PsuOk = 2'b01; PsuFail = 2'b10; FanFail = 1'b0; run(3);
    LanLink1000 = 2'b01; LanLink100 = 2'b11; run(3);
    // Continuous activity on port 0, then link drop mid-ON.
    LanLink1000 = 2'b01; LanLink100 = 2'b00; LanAct = 2'b01; run(28);
    LanLink1000 = 2'b00; run(4);
    LanLink1000 = 2'b01; LanAct = 2'b00; run(2);
    LanAct = 2'b01; run(1); LanAct = 2'b00; run(12);
    // Lamp-test abort during TEST_ON, then full rerun.
    FM_PS_EN = 1'b0; run(3);
    FM_PS_EN = 1'b1; run(6);
    FM_PS_EN = 1'b0; run(3);
    FM_PS_EN = 1'b1; run(30);
    // Randomized traffic with occasional power toggles, link flaps and resets.
    for (int k = 0; k < 3000; k++) begin
      Reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 63) == 0) FM_PS_EN = ~FM_PS_EN;
      if ($urandom_range(0, 15) == 0) begin
        SysGreenMode = 2'($urandom); SysRedMode = 2'($urandom);
        PsuOk = 2'($urandom); PsuFail = 2'($urandom); FanFail = 1'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        LanLink1000 = 2'($urandom); LanLink100 = 2'($urandom);
      end
      LanAct = 2'($urandom) & 2'($urandom);
      tick();
    end
    #1;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
